// File: rtl/cr16_pkg.sv
// cr16_pkg: CR16 instruction codes, ALU opcodes and controller FSM states.
package cr16_pkg;
  localparam logic [3:0] OP_RR  = 4'b0000;
  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1011;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_CMP = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;
  localparam logic [3:0] ALU_MOV = 4'd6;
  typedef enum logic [1:0] {IDLE, DECODE, EXECUTE} state_t;
endpackage

// File: rtl/instruction_controller_if.sv
// instruction_controller_if: instruction handshake and decoded control bus.
interface instruction_controller_if;
  logic [15:0] I_INSTR;
  logic        I_INSTR_VALID;
  logic        O_INSTR_READY;
  logic [15:0] O_REG_WRITE_ENABLE;
  logic [3:0]  O_REG_A_SELECT;
  logic [3:0]  O_REG_B_SELECT;
  logic [15:0] O_IMMEDIATE;
  logic        O_IMMEDIATE_SELECT;
  logic [3:0]  O_OPCODE;
  logic        O_ILLEGAL;
  logic [15:0] O_RETIRED_COUNT;
  modport master (
    output I_INSTR, I_INSTR_VALID,
    input  O_INSTR_READY, O_REG_WRITE_ENABLE, O_REG_A_SELECT, O_REG_B_SELECT,
           O_IMMEDIATE, O_IMMEDIATE_SELECT, O_OPCODE, O_ILLEGAL, O_RETIRED_COUNT
  );
  modport slave (
    input  I_INSTR, I_INSTR_VALID,
    output O_INSTR_READY, O_REG_WRITE_ENABLE, O_REG_A_SELECT, O_REG_B_SELECT,
           O_IMMEDIATE, O_IMMEDIATE_SELECT, O_OPCODE, O_ILLEGAL, O_RETIRED_COUNT
  );
endinterface

// File: rtl/instruction_decoder.sv
// instruction_decoder: combinational CR16 decode of ALU op, immediate and legality.
module instruction_decoder
  import cr16_pkg::*;
(
  input  logic [15:0] instr,
  output logic [3:0]  alu_op,
  output logic        imm_sel,
  output logic [15:0] imm,
  output logic        wr_suppress,
  output logic        illegal
);
  logic [3:0] code;
  logic       sext;
  always_comb begin
    imm_sel = instr[15:12] != OP_RR;
    code = imm_sel ? instr[15:12] : instr[7:4];
    alu_op = ALU_ADD;
    sext = 1'b0;
    illegal = 1'b0;
    case (code)
      OP_AND: alu_op = ALU_AND;
      OP_OR:  alu_op = ALU_OR;
      OP_XOR: alu_op = ALU_XOR;
      OP_ADD: sext = 1'b1;
      OP_SUB: begin alu_op = ALU_SUB; sext = 1'b1; end
      OP_CMP: begin alu_op = ALU_CMP; sext = 1'b1; end
      OP_MOV: alu_op = ALU_MOV;
      default: illegal = 1'b1;
    endcase
    wr_suppress = code == OP_CMP;
    imm = (!imm_sel || illegal) ? 16'h0000 : {sext ? {8{instr[7]}} : 8'h00, instr[7:0]};
  end
endmodule

// File: rtl/instruction_controller.sv
// instruction_controller: IDLE/DECODE/EXECUTE sequencer driving registered CR16 control outputs.
module instruction_controller
  import cr16_pkg::*;
(
  input logic I_CLK,
  input logic I_NRESET,
  instruction_controller_if.slave bus
);
  state_t      state, next_state;
  logic [15:0] instr_q, instr_d, dec_imm, wen, imm, count;
  logic [3:0]  dec_op, a_sel, b_sel, opcode;
  logic        dec_isel, dec_supp, dec_ill, isel, supp_q, ill_q, ill_pulse, accept;
  // Decoding the next instruction-register value lets outputs be valid from the first DECODE cycle.
  instruction_decoder u_dec (
    .instr(instr_d), .alu_op(dec_op), .imm_sel(dec_isel), .imm(dec_imm),
    .wr_suppress(dec_supp), .illegal(dec_ill)
  );
  assign bus.O_INSTR_READY = state == IDLE && I_NRESET;
  assign accept = bus.I_INSTR_VALID && bus.O_INSTR_READY;
  assign instr_d = accept ? bus.I_INSTR : instr_q;
  always_comb begin
    next_state = state == IDLE ? (accept ? DECODE : IDLE) :
                 (state == DECODE && !ill_q) ? EXECUTE : IDLE;
  end
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state <= IDLE;
      instr_q <= '0;
      a_sel <= '0;
      b_sel <= '0;
      opcode <= '0;
      imm <= '0;
      isel <= 1'b0;
      supp_q <= 1'b0;
      ill_q <= 1'b0;
      wen <= '0;
      ill_pulse <= 1'b0;
      count <= '0;
    end else begin
      state <= next_state;
      instr_q <= instr_d;
      a_sel <= instr_d[11:8];
      b_sel <= dec_isel ? 4'h0 : instr_d[3:0];
      opcode <= dec_op;
      imm <= dec_imm;
      isel <= dec_isel;
      supp_q <= dec_supp;
      ill_q <= dec_ill;
      wen <= (next_state == EXECUTE && !supp_q) ? 16'h0001 << instr_q[11:8] : 16'h0000;
      ill_pulse <= state == DECODE && ill_q;
      if (state == EXECUTE) count <= count + 16'h0001;
    end
  end
  assign bus.O_REG_WRITE_ENABLE = wen;
  assign bus.O_REG_A_SELECT = a_sel;
  assign bus.O_REG_B_SELECT = b_sel;
  assign bus.O_IMMEDIATE = imm;
  assign bus.O_IMMEDIATE_SELECT = isel;
  assign bus.O_OPCODE = opcode;
  assign bus.O_ILLEGAL = ill_pulse;
  assign bus.O_RETIRED_COUNT = count;
endmodule

// File: tb/tb_instruction_controller.sv
// tb_instruction_controller: scoreboard bench; stimulus queues expected transactions, a monitor checks completions.
module tb_instruction_controller;
  logic I_CLK = 1'b0;
  logic I_NRESET;
  instruction_controller_if bus ();
  instruction_controller dut (.I_CLK(I_CLK), .I_NRESET(I_NRESET), .bus(bus));
  always #5 I_CLK = ~I_CLK;

  typedef struct {
    logic [3:0]  a, b, op;
    logic [15:0] imm;
    logic        isel;
    logic [15:0] wen;
    int          busy;
    logic [15:0] cd;
    logic        ill;
    logic        ctl;
  } exp_t;

  exp_t q[$];
  int starts[$];
  int n_chk = 0, n_fail = 0, cyc = 0, ill_pulses = 0;
  bit tracking = 0, stable;
  int busy;
  logic [3:0]  s_a, s_b, s_op;
  logic [15:0] s_imm, s_c0, w_dec, w_exe, dcount;
  logic        s_isel;
  exp_t        e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ok(logic [3:0] a, logic [3:0] b, logic [3:0] op,
                              logic [15:0] imm, logic isel, logic [15:0] wen);
    exp_t r;
    r.a = a; r.b = b; r.op = op; r.imm = imm; r.isel = isel; r.wen = wen;
    r.busy = 2; r.cd = 16'd1; r.ill = 1'b0; r.ctl = 1'b1;
    return r;
  endfunction

  function automatic exp_t bad();
    exp_t r;
    r.a = 0; r.b = 0; r.op = 0; r.imm = 0; r.isel = 0; r.wen = 0;
    r.busy = 1; r.cd = 16'd0; r.ill = 1'b1; r.ctl = 1'b0;
    return r;
  endfunction

  always @(posedge I_CLK) cyc++;

  always @(negedge I_CLK) begin
    if (!I_NRESET) tracking = 0;
    else if (!bus.O_INSTR_READY) begin
      if (!tracking) begin
        tracking = 1; busy = 0; stable = 1;
        s_a = bus.O_REG_A_SELECT; s_b = bus.O_REG_B_SELECT; s_op = bus.O_OPCODE;
        s_imm = bus.O_IMMEDIATE; s_isel = bus.O_IMMEDIATE_SELECT;
        s_c0 = bus.O_RETIRED_COUNT; w_dec = bus.O_REG_WRITE_ENABLE; w_exe = 0;
        starts.push_back(cyc);
      end else begin
        stable &= s_a == bus.O_REG_A_SELECT && s_b == bus.O_REG_B_SELECT && s_op == bus.O_OPCODE &&
                  s_imm == bus.O_IMMEDIATE && s_isel == bus.O_IMMEDIATE_SELECT;
        w_exe = bus.O_REG_WRITE_ENABLE;
      end
      busy++;
    end else if (tracking) begin
      tracking = 0;
      if (q.size() == 0) chk("unexpected_completion", 1, 0);
      else begin
        e = q.pop_front();
        dcount = bus.O_RETIRED_COUNT - s_c0;
        chk("busy_cycles", busy, e.busy);
        chk("wen_in_decode", w_dec, 0);
        chk("wen_in_execute", w_exe, e.wen);
        chk("wen_in_idle", bus.O_REG_WRITE_ENABLE, 0);
        chk("illegal_pulse", bus.O_ILLEGAL, e.ill);
        chk("retired_delta", dcount, e.cd);
        if (e.ctl) begin
          chk("a_select", s_a, e.a);
          chk("b_select", s_b, e.b);
          chk("opcode", s_op, e.op);
          chk("immediate", s_imm, e.imm);
          chk("imm_select", s_isel, e.isel);
          chk("ctl_held", stable, 1);
        end
      end
    end
    if (bus.O_ILLEGAL) ill_pulses++;
  end

  task automatic issue(input logic [15:0] w, input exp_t x, input bit push);
    int n = 0;
    while (!bus.O_INSTR_READY && n < 20) begin @(posedge I_CLK); #1; n++; end
    chk("ready_wait", bus.O_INSTR_READY, 1);
    if (push) q.push_back(x);
    bus.I_INSTR = w; bus.I_INSTR_VALID = 1'b1;
    @(posedge I_CLK); #1;
    bus.I_INSTR_VALID = 1'b0; bus.I_INSTR = ~w;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || tracking) && n < 50) begin @(posedge I_CLK); #1; n++; end
    chk("drain_left", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] trio [3];
    trio[0] = 16'h0752; trio[1] = 16'h53FF; trio[2] = 16'h04B5;
    I_NRESET = 1'b0; bus.I_INSTR = 16'h0000; bus.I_INSTR_VALID = 1'b0;
    repeat (2) @(posedge I_CLK); #1;
    chk("rst_ready", bus.O_INSTR_READY, 0);
    chk("rst_wen", bus.O_REG_WRITE_ENABLE, 0);
    chk("rst_count", bus.O_RETIRED_COUNT, 0);
    chk("rst_opcode", bus.O_OPCODE, 0);
    I_NRESET = 1'b1;
    #1 chk("ready_after_rst", bus.O_INSTR_READY, 1);
    issue(16'h53FF, ok(3, 0, 4'd0, 16'hFFFF, 1, 16'h0008), 1);
    issue(16'h0752, ok(7, 2, 4'd0, 16'h0000, 0, 16'h0080), 1);
    issue(16'h1180, ok(1, 0, 4'd3, 16'h0080, 1, 16'h0002), 1);
    issue(16'h04B5, ok(4, 5, 4'd2, 16'h0000, 0, 16'h0000), 1);
    issue(16'hF000, bad(), 1);
    issue(16'h9280, ok(2, 0, 4'd1, 16'hFF80, 1, 16'h0004), 1);
    issue(16'hDA80, ok(10, 0, 4'd6, 16'h0080, 1, 16'h0400), 1);
    issue(16'h0F3C, ok(15, 12, 4'd5, 16'h0000, 0, 16'h8000), 1);
    issue(16'h0140, bad(), 1);
    issue(16'h2E7F, ok(14, 0, 4'd4, 16'h007F, 1, 16'h4000), 1);
    issue(16'hB0FE, ok(0, 0, 4'd2, 16'hFFFE, 1, 16'h0000), 1);
    issue(16'h0000, bad(), 1);
    drain();
    chk("retired_after_mix", bus.O_RETIRED_COUNT, 9);
    // Valid held high for three instructions; I_INSTR is scrambled while each is in DECODE.
    starts.delete();
    q.push_back(ok(7, 2, 4'd0, 16'h0000, 0, 16'h0080));
    q.push_back(ok(3, 0, 4'd0, 16'hFFFF, 1, 16'h0008));
    q.push_back(ok(4, 5, 4'd2, 16'h0000, 0, 16'h0000));
    bus.I_INSTR = trio[0]; bus.I_INSTR_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge I_CLK); #1; bus.I_INSTR = 16'hF000;
      @(posedge I_CLK); #1; bus.I_INSTR = (i < 2) ? trio[i+1] : 16'h0000;
      @(posedge I_CLK); #1;
    end
    bus.I_INSTR_VALID = 1'b0;
    drain();
    chk("b2b_accepts", starts.size(), 3);
    if (starts.size() == 3) begin
      chk("b2b_gap0", starts[1] - starts[0], 3);
      chk("b2b_gap1", starts[2] - starts[1], 3);
    end
    // Reset in EXECUTE aborts the instruction.
    issue(16'h5305, ok(3, 0, 4'd0, 16'h0005, 1, 16'h0008), 0);
    @(posedge I_CLK); #1;
    chk("wen_before_abort", bus.O_REG_WRITE_ENABLE, 16'h0008);
    I_NRESET = 1'b0;
    #1;
    chk("abort_wen", bus.O_REG_WRITE_ENABLE, 0);
    chk("abort_a", bus.O_REG_A_SELECT, 0);
    chk("abort_b", bus.O_REG_B_SELECT, 0);
    chk("abort_imm", bus.O_IMMEDIATE, 0);
    chk("abort_isel", bus.O_IMMEDIATE_SELECT, 0);
    chk("abort_opcode", bus.O_OPCODE, 0);
    chk("abort_illegal", bus.O_ILLEGAL, 0);
    chk("abort_count", bus.O_RETIRED_COUNT, 0);
    chk("abort_ready", bus.O_INSTR_READY, 0);
    bus.I_INSTR = 16'h0752; bus.I_INSTR_VALID = 1'b1;
    repeat (2) @(posedge I_CLK); #1;
    chk("count_after_abort", bus.O_RETIRED_COUNT, 0);
    q.push_back(ok(7, 2, 4'd0, 16'h0000, 0, 16'h0080));
    I_NRESET = 1'b1;
    @(posedge I_CLK); #1;
    bus.I_INSTR_VALID = 1'b0;
    chk("first_edge_accept", bus.O_INSTR_READY, 0);
    drain();
    chk("count_post_reset", bus.O_RETIRED_COUNT, 1);
    // Counter wrap from 0xFFFF.
    force dut.count = 16'hFFFF;
    @(negedge I_CLK);
    release dut.count;
    #1 chk("count_preload", bus.O_RETIRED_COUNT, 16'hFFFF);
    issue(16'h53FF, ok(3, 0, 4'd0, 16'hFFFF, 1, 16'h0008), 1);
    drain();
    chk("count_wrap", bus.O_RETIRED_COUNT, 16'h0000);
    chk("illegal_pulses_total", ill_pulses, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/instruction_controller.md
INSTRUCTION_CONTROLLER -- requirements
Module: instruction_controller

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: I_CLK and I_NRESET.
REQ-002 The block SHALL have these ports:
- I_CLK, input, 1: rising-edge clock
- I_NRESET, input, 1: async active-low reset
- I_INSTR, input, 16: CR16 instruction word
- I_INSTR_VALID, input, 1: instruction offered
- O_INSTR_READY, output, 1: controller can accept
- O_REG_WRITE_ENABLE, output, 16: one-hot register write enable
- O_REG_A_SELECT, output, 4: binary A-operand register
- O_REG_B_SELECT, output, 4: binary B-operand register
- O_IMMEDIATE, output, 16: extended immediate
- O_IMMEDIATE_SELECT, output, 1: B operand is the immediate
- O_OPCODE, output, 4: ALU opcode
- O_ILLEGAL, output, 1: one-cycle pulse for an undecodable instruction
- O_RETIRED_COUNT, output, 16: count of completed instructions

Function
REQ-003 The instruction format SHALL be [15:12] op, [11:8] Rdest, [7:4] ext or ImmHi, [3:0] Rsrc or ImmLo.
REQ-004 Register-register instructions (op=0000) SHALL decode ext: AND=0001, OR=0010, XOR=0011, ADD=0101, SUB=1001, CMP=1011, MOV=1101.
REQ-005 Immediate instructions SHALL use the same codes in op (ANDI, ORI, XORI, ADDI, SUBI, CMPI, MOVI), with Imm = [7:0].
REQ-006 Any other op/ext combination SHALL be illegal.
REQ-007 The FSM SHALL have states IDLE, DECODE and EXECUTE; the reset state SHALL be IDLE.
REQ-008 O_INSTR_READY SHALL be 1 only in IDLE with I_NRESET high.
- IDLE->DECODE on the edge where I_INSTR_VALID and O_INSTR_READY are both 1.
- I_INSTR SHALL be captured into an internal instruction register on that edge.
REQ-009 DECODE->EXECUTE SHALL occur after exactly one cycle for a legal instruction.
- For an illegal instruction, DECODE->IDLE SHALL occur and O_ILLEGAL SHALL pulse for exactly one cycle, in the first IDLE cycle.
REQ-010 EXECUTE->IDLE SHALL occur after exactly one cycle.
REQ-011 Control outputs SHALL be registered and held constant through DECODE and EXECUTE:
- O_REG_A_SELECT = Rdest; O_REG_B_SELECT = Rsrc (0 for immediate forms); O_OPCODE per the package map; O_IMMEDIATE_SELECT = 1 for immediate forms.
REQ-012 O_REG_WRITE_ENABLE SHALL be 0 in IDLE and DECODE.
- In EXECUTE it SHALL be 1<<Rdest, except CMP/CMPI, which SHALL write nothing.
REQ-013 Immediate extension:
- ADDI, SUBI, CMPI: sign-extend Imm[7] to 16 bits.
- ANDI, ORI, XORI, MOVI: zero-extend.
- Register-register forms: O_IMMEDIATE = 0.
REQ-014 Latency SHALL be fixed: accept at edge N, register write at edge N+2, O_INSTR_READY high again in the cycle after edge N+2.
- The maximum throughput SHALL be one instruction per 3 cycles.
REQ-015 O_RETIRED_COUNT SHALL increment on each EXECUTE->IDLE transition, including CMP/CMPI, and wrap 0xFFFF->0x0000; illegal instructions SHALL not count.
REQ-016 I_INSTR_VALID SHALL be ignored outside IDLE, and changes to I_INSTR after acceptance SHALL have no effect.
REQ-017 Back-to-back valid instructions SHALL be accepted in the first IDLE cycle after EXECUTE.

Reset
REQ-018 When I_NRESET is low, the following SHALL be 0 immediately, independent of the clock:
- state = IDLE; instruction register = 0
- O_REG_WRITE_ENABLE, O_REG_A_SELECT, O_REG_B_SELECT, O_IMMEDIATE, O_IMMEDIATE_SELECT, O_OPCODE, O_ILLEGAL, O_RETIRED_COUNT
REQ-019 Reset asserted in DECODE or EXECUTE SHALL abort the instruction with no write and no count increment.
REQ-020 After reset deasserts, the block SHALL accept an instruction on the first qualifying edge.

Structure
REQ-021 A shared package cr16_pkg SHALL hold:
- the instruction op/ext code constants;
- ALU opcode constants: ALU_ADD=4'd0, ALU_SUB=4'd1, ALU_CMP=4'd2, ALU_AND=4'd3, ALU_OR=4'd4, ALU_XOR=4'd5, ALU_MOV=4'd6;
- the FSM state enum.
REQ-022 Decoding SHALL live in one combinational sub-module, instruction_decoder.
- Input: the instruction register.
- Outputs: ALU opcode, immediate select, extended immediate, write-suppress, illegal.
- The FSM and output registers SHALL remain in instruction_controller.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- ADDI r3,#-1: 0x53FF accepted at edge N -> O_IMMEDIATE=0xFFFF, O_IMMEDIATE_SELECT=1, O_OPCODE=ALU_ADD, O_REG_A_SELECT=3; O_REG_WRITE_ENABLE=0x0008 only in the cycle before edge N+2; count +1.
- ADD r7,r2: 0x0752 -> O_REG_A_SELECT=7, O_REG_B_SELECT=2, O_IMMEDIATE_SELECT=0, O_REG_WRITE_ENABLE=0x0080 in EXECUTE.
- ANDI r1,#0x80: 0x5180 with op=0001, i.e. 0x1180 -> O_IMMEDIATE=0x0080 (zero-extended); CMP r4,r5: 0x04B5 -> write enable stays 0x0000 and count still increments.
- Illegal 0xF000 -> O_ILLEGAL pulses exactly once, no write enable, count unchanged, O_INSTR_READY returns 2 cycles after accept.
- I_INSTR_VALID held high with three instructions -> accepts spaced exactly 3 cycles apart; changing I_INSTR in DECODE has no effect.
- I_NRESET pulsed low during EXECUTE of 0x5305 -> no write, all outputs 0 immediately; preload count 0xFFFF then retire one -> 0x0000.
